// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder stage applied LSB first, then {carry,sum} is registered.
// Latency: start accepted at edge k gives done and a valid result in the cycle after edge k+WIDTH.
// Backpressure: none; start is ignored while busy, and held-high start repeats every WIDTH+2 cycles.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CW = (WIDTH == 1) ? 1 : $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_nxt;
    logic             c_reg;
    logic             s_bit;
    logic             c_nxt;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    always_comb begin
        s_bit           = a_sh[0] ^ b_sh[0] ^ c_reg;
        c_nxt           = (a_sh[0] & b_sh[0]) | (a_sh[0] & c_reg) | (b_sh[0] & c_reg);
        r_nxt           = r_sh >> 1;
        r_nxt[WIDTH-1]  = s_bit;
        last_bit        = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operands are copied into shift registers so the inputs are free to change mid-operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            c_reg <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a_in;
                        b_sh  <= b_in;
                        c_reg <= c_in;
                        r_sh  <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r_sh  <= r_nxt;
                    c_reg <= c_nxt;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        sum   <= r_nxt;
                        carry <= c_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1 side by side.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       c8 = 1'b0;
    logic       busy8, done8, carry8;
    logic [7:0] sum8;
    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       c1 = 1'b0;
    logic       busy1, done1, carry1;
    logic [0:0] sum1;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .c_in(c8),
        .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1), .c_in(c1),
        .busy(busy1), .done(done1), .sum(sum1), .carry(carry1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [32:0] val;
        int          acc;
    } exp_t;

    exp_t        sbq [2][$];
    int          free_at [2];
    int          acc_cnt [2];
    logic [32:0] last [2];
    logic        prev_done [2];
    int          ncyc = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h, want %h", nm, ncyc, act, want);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            sbq[i].delete();
            free_at[i]   = 0;
            last[i]      = '0;
            prev_done[i] = 1'b0;
        end
    endtask

    // Reference: an accepted start yields a+b+c exactly, and the block is free WIDTH+2 cycles later.
    task automatic pred_step(input int id, input int w, input logic s,
                             input logic [31:0] a, input logic [31:0] b, input logic c);
        exp_t e;
        if (!rst && s && ncyc >= free_at[id]) begin
            e.val = {1'b0, a} + {1'b0, b} + {32'b0, c};
            e.acc = ncyc;
            sbq[id].push_back(e);
            free_at[id] = ncyc + w + 2;
            acc_cnt[id]++;
        end
    endtask

    task automatic mon_step(input int id, input int w, input logic bsy, input logic dn,
                            input logic [31:0] sm, input logic cy);
        logic [32:0] act;
        exp_t        e;
        logic        want_busy;
        act = {1'b0, sm} | ({32'b0, cy} << w);
        if (rst) begin
            chk("rst_busy", {32'b0, bsy}, 33'd0);
            chk("rst_done", {32'b0, dn}, 33'd0);
            chk("rst_result", act, 33'd0);
            prev_done[id] = 1'b0;
            return;
        end
        want_busy = (sbq[id].size() != 0) && (ncyc >= sbq[id][0].acc + 1);
        chk("busy", {32'b0, bsy}, {32'b0, want_busy});
        if (dn) begin
            chk("done_twice", {32'b0, prev_done[id]}, 33'd0);
            if (sbq[id].size() == 0) begin
                chk("unexpected_done", {32'b0, dn}, 33'd0);
            end else begin
                e = sbq[id].pop_front();
                chk("done_latency", 33'(ncyc - e.acc), 33'(w + 1));
                last[id] = e.val;
            end
        end else if (sbq[id].size() != 0 && ncyc > sbq[id][0].acc + w + 1) begin
            chk("done_missing", {32'b0, dn}, 33'd1);
            void'(sbq[id].pop_front());
        end
        chk("result", act, last[id]);
        prev_done[id] = dn;
    endtask

    always @(negedge clk) begin
        pred_step(0, 8, start8, {24'b0, a8}, {24'b0, b8}, c8);
        pred_step(1, 1, start1, {31'b0, a1}, {31'b0, b1}, c1);
    end

    always @(negedge clk) begin
        mon_step(0, 8, busy8, done8, {24'b0, sum8}, carry8);
        mon_step(1, 1, busy1, done1, {31'b0, sum1}, carry1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [8:0] want);
        a8 = a; b8 = b; c8 = c; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
        repeat (9) tick();
        chk("op8_const", {24'b0, carry8, sum8}, {24'b0, want});
    endtask

    task automatic op1(input logic a, input logic b, input logic c, input logic [1:0] want);
        a1 = a; b1 = b; c1 = c; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        a1 = ~a1; b1 = ~b1; c1 = ~c1;
        repeat (2) tick();
        chk("op1_const", {31'b0, carry1, sum1}, {31'b0, want});
    endtask

    initial begin
        int target8;
        int target1;
        for (int i = 0; i < 2; i++) acc_cnt[i] = 0;
        clear_model();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_state", {30'b0, busy8, done8, carry8}, 33'd0);

        op8(8'h00, 8'h00, 1'b0, 9'h000);
        op8(8'hFF, 8'h01, 1'b0, 9'h100);
        op8(8'hA5, 8'h5A, 1'b1, 9'h100);
        op8(8'h3C, 8'h42, 1'b0, 9'h07E);
        op1(1'b1, 1'b1, 1'b1, 2'd3);
        op1(1'b0, 1'b0, 1'b0, 2'd0);
        op1(1'b1, 1'b0, 1'b1, 2'd2);

        // A start pulsed mid-run must not disturb the operation in flight.
        a8 = 8'h3C; b8 = 8'h42; c8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (2) tick();
        a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (6) tick();
        chk("ignored_start", {24'b0, carry8, sum8}, 33'h07E);

        a8 = 8'h0F; b8 = 8'hF0; c8 = 1'b1; start8 = 1'b1;
        repeat (30) tick();
        start8 = 1'b0;
        repeat (12) tick();
        chk("held_start", {24'b0, carry8, sum8}, 33'h100);

        // Abort in the fourth RUN cycle.
        a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        clear_model();
        #1;
        chk("abort_busy", {32'b0, busy8}, 33'd0);
        chk("abort_done", {32'b0, done8}, 33'd0);
        chk("abort_result", {24'b0, carry8, sum8}, 33'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        op8(8'hA5, 8'h5A, 1'b1, 9'h100);

        target8 = acc_cnt[0] + 1000;
        target1 = acc_cnt[1] + 16;
        fork
            begin
                for (int g = 0; g < 30000 && acc_cnt[0] < target8; g++) begin
                    start8 = ($urandom_range(3) != 0);
                    a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
                    tick();
                end
                start8 = 1'b0;
            end
            begin
                for (int g = 0; g < 2000 && acc_cnt[1] < target1; g++) begin
                    start1 = ($urandom_range(3) != 0);
                    a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
                    tick();
                end
                start1 = 1'b0;
            end
        join
        repeat (15) tick();
        chk("random_count8", 33'(acc_cnt[0] >= target8), 33'd1);
        chk("random_count1", 33'(acc_cnt[1] >= target1), 33'd1);
        chk("drained8", 33'(sbq[0].size()), 33'd0);
        chk("drained1", 33'(sbq[1].size()), 33'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 1 to 32.
REQ-002 clk  input  1  single clock; all registers update on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin an addition; sampled on the rising edge of clk.
REQ-005 a_in  input  WIDTH  operand A; captured on an accepted start.
REQ-006 b_in  input  WIDTH  operand B; captured on an accepted start.
REQ-007 c_in  input  1  carry-in; captured on an accepted start.
REQ-008 busy  output  1  high while an operation is in progress or completing (state RUN or DONE).
REQ-009 done  output  1  one-cycle completion strobe.
REQ-010 sum  output  WIDTH  registered result of the last completed addition.
REQ-011 carry  output  1  registered carry-out of the last completed addition.

Function
REQ-012 The block shall sequence one 1-bit full-adder stage over WIDTH cycles, LSB first: s = a^b^c, c' = (a&b)|(a&c)|(b&c).
REQ-013 States: IDLE, RUN, DONE; encoding is free; no other reachable states.
REQ-014 IDLE: if start=1 at an edge, load a_in, b_in and c_in into internal shift and carry registers, clear the bit counter and go to RUN; else stay in IDLE.
REQ-015 RUN: each edge processes the current LSB pair with the carry register, shifts the resulting sum bit into the result shift register from the MSB side, updates the carry register and increments the bit counter.
REQ-016 RUN: on the edge that processes bit WIDTH-1, copy the assembled result to sum, copy the final carry to carry, and go to DONE.
REQ-017 DONE: done=1 for exactly this one cycle; the next edge returns to IDLE unconditionally.
REQ-018 Latency: if start is accepted at edge k, done is high in the cycle following edge k+WIDTH, and sum/carry are valid in that same cycle.
REQ-019 sum and carry shall hold their values from DONE until the next completion; they do not change during RUN.
REQ-020 start is ignored in RUN and DONE; operands presented then are not captured.
REQ-021 If start is held high continuously, a new operation shall be accepted on the first edge in IDLE, so consecutive operations are spaced WIDTH+2 cycles apart.
REQ-022 a_in, b_in and c_in may change freely after the accepting edge without affecting the result in progress.
REQ-023 Arithmetic: {carry,sum} = a_in + b_in + c_in, computed modulo 2^(WIDTH+1) with no overflow loss.
REQ-024 The bit counter shall be ceil(log2(WIDTH))+1 bits wide, or 1 bit when WIDTH=1; for WIDTH=1, RUN lasts exactly one cycle.
REQ-025 busy is driven from state registers only, with no combinational path from start.

Reset
REQ-026 rst=1 shall immediately force state IDLE, busy=0, done=0, sum=0, carry=0, and clear the counter and internal registers, independent of clk.
REQ-027 Reset asserted during RUN or DONE shall abort the operation: no done pulse is produced and the outputs are zero.
REQ-028 After rst is deasserted, the first rising edge with start=1 shall be accepted.

Verification
REQ-029 WIDTH=8, start with a=0x00, b=0x00, c=0 -> busy for 9 cycles; done pulse 8 cycles after the accepting edge; sum=0x00, carry=0.
REQ-030 a=0xFF, b=0x01, c=0 -> sum=0x00, carry=1; a=0xA5, b=0x5A, c=1 -> sum=0x00, carry=1; a=0x3C, b=0x42, c=0 -> sum=0x7E, carry=0.
REQ-031 During RUN, pulse start with a=0x11, b=0x22 -> ignored; the result equals the first operation's result; exactly one done pulse.
REQ-032 start held high for 30 cycles with constant operands -> done pulses exactly 10 cycles apart; sum is stable between pulses.
REQ-033 Assert rst at the 4th RUN cycle -> busy, done, sum and carry go to 0 immediately; no done pulse; a following start=1 completes normally.
REQ-034 Random self-check: 1000 random operand triples at WIDTH=8 and 16 sets at WIDTH=1, each compared against a+b+c; zero mismatches; done is never high for two consecutive cycles.
